// File: rtl/flexsoc_rst_pkg.sv
// Shared types and constants for the flexsoc reset sequencer.
package flexsoc_rst_pkg;

    typedef enum logic [2:0] {
        ASSERT = 3'd0,
        COUNT  = 3'd1,
        DBG_UP = 3'd2,
        RUN    = 3'd3,
        SYSREQ = 3'd4
    } rst_state_t;

    localparam int CAUSE_POR    = 0;
    localparam int CAUSE_BTN    = 1;
    localparam int CAUSE_LOCK   = 2;
    localparam int CAUSE_SYSREQ = 3;

    localparam logic [3:0] POR_CAUSE    = 4'(1 << CAUSE_POR);
    localparam logic [3:0] SYSREQ_CAUSE = 4'(1 << CAUSE_SYSREQ);

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/flexsoc_sync2.sv
// Two-flop synchroniser with asynchronous active-low clear; output resets to 0.
module flexsoc_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/flexsoc_reset_seq.sv
// Reset sequencer: combines POR, debounced button, PLL locks and SYSRESETREQ
// into staged DBGRESETn / SYSRESETn releases with a sticky cause register.
//
// state  | meaning
// ASSERT | both resets low, waiting for a clean cycle
// COUNT  | hold count running, DBGRESETn releases at terminal count
// DBG_UP | debug side up, SYSRESETn releases at terminal count
// RUN    | both resets released
// SYSREQ | core-requested reset, SYSRESETn low for SYSREQ_CYCLES
module flexsoc_reset_seq
    import flexsoc_rst_pkg::*;
#(
    parameter int unsigned NPLL            = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned HOLD_CYCLES     = 15,
    parameter int unsigned SYS_DELAY       = 8,
    parameter int unsigned SYSREQ_CYCLES   = 4
) (
    input  logic            CLK,
    input  logic            PORESETn,
    input  logic            BTN_RESET,
    input  logic [NPLL-1:0] PLL_LOCKED,
    input  logic            SYSRESETREQ,
    output logic            DBGRESETn,
    output logic            SYSRESETn,
    output logic [3:0]      RESET_CAUSE
);

    localparam int unsigned CNT_MAX = max3(HOLD_CYCLES, SYS_DELAY, SYSREQ_CYCLES);
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
    localparam int unsigned DW      = $clog2(DEBOUNCE_CYCLES) + 1;

    logic            btn_sync;
    logic            btn_db;
    logic [DW-1:0]   db_cnt;
    logic [NPLL-1:0] lock_sync;
    logic            lock_lost;
    logic            fault;
    logic [3:0]      fault_cause;

    rst_state_t      state;
    logic [CW-1:0]   cnt;

    flexsoc_sync2 #(.WIDTH(1)) u_sync_btn (
        .clk   (CLK),
        .rst_n (PORESETn),
        .d     (BTN_RESET),
        .q     (btn_sync)
    );

    flexsoc_sync2 #(.WIDTH(NPLL)) u_sync_lock (
        .clk   (CLK),
        .rst_n (PORESETn),
        .d     (PLL_LOCKED),
        .q     (lock_sync)
    );

    // Counter only advances while the synced button disagrees with the debounced value
    always_ff @(posedge CLK or negedge PORESETn) begin
        if (!PORESETn) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_sync != btn_db) begin
            if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    always_comb begin
        lock_lost                = ~&lock_sync;
        fault                    = lock_lost | btn_db;
        fault_cause              = '0;
        fault_cause[CAUSE_LOCK]  = lock_lost;
        fault_cause[CAUSE_BTN]   = btn_db;
    end

    // Both resets drop together on ASSERT entry and SYSREQ only touches SYSRESETn,
    // so SYSRESETn can never be high while DBGRESETn is low.
    always_ff @(posedge CLK or negedge PORESETn) begin
        if (!PORESETn) begin
            state       <= ASSERT;
            cnt         <= '0;
            DBGRESETn   <= 1'b0;
            SYSRESETn   <= 1'b0;
            RESET_CAUSE <= POR_CAUSE;
        end else if (fault && state != ASSERT) begin
            state       <= ASSERT;
            cnt         <= '0;
            DBGRESETn   <= 1'b0;
            SYSRESETn   <= 1'b0;
            RESET_CAUSE <= fault_cause;
        end else begin
            case (state)
                ASSERT: begin
                    if (!fault) begin
                        state <= COUNT;
                        cnt   <= CW'(HOLD_CYCLES);
                    end
                end
                COUNT: begin
                    if (cnt == CW'(1)) begin
                        state     <= DBG_UP;
                        DBGRESETn <= 1'b1;
                        cnt       <= CW'(SYS_DELAY);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DBG_UP: begin
                    if (cnt == CW'(1)) begin
                        state     <= RUN;
                        SYSRESETn <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RUN: begin
                    if (SYSRESETREQ) begin
                        state       <= SYSREQ;
                        SYSRESETn   <= 1'b0;
                        cnt         <= CW'(SYSREQ_CYCLES);
                        RESET_CAUSE <= SYSREQ_CAUSE;
                    end
                end
                SYSREQ: begin
                    if (cnt == CW'(1)) begin
                        state     <= RUN;
                        SYSRESETn <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state     <= ASSERT;
                    cnt       <= '0;
                    DBGRESETn <= 1'b0;
                    SYSRESETn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flexsoc_reset_seq.sv
// Directed bench for flexsoc_reset_seq with short debounce/hold parameters.
module tb_flexsoc_reset_seq;

    logic       CLK         = 1'b0;
    logic       PORESETn    = 1'b1;
    logic       BTN_RESET   = 1'b0;
    logic [1:0] PLL_LOCKED  = 2'b11;
    logic       SYSRESETREQ = 1'b0;
    logic       DBGRESETn;
    logic       SYSRESETn;
    logic [3:0] RESET_CAUSE;

    int errors = 0;
    int checks = 0;

    flexsoc_reset_seq #(
        .NPLL            (2),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (15),
        .SYS_DELAY       (8),
        .SYSREQ_CYCLES   (4)
    ) dut (
        .CLK         (CLK),
        .PORESETn    (PORESETn),
        .BTN_RESET   (BTN_RESET),
        .PLL_LOCKED  (PLL_LOCKED),
        .SYSRESETREQ (SYSRESETREQ),
        .DBGRESETn   (DBGRESETn),
        .SYSRESETn   (SYSRESETn),
        .RESET_CAUSE (RESET_CAUSE)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #2 PORESETn = 1'b0;
        #1;
        checks++; if (DBGRESETn !== 1'b0) begin errors++; $display("FAIL rst_dbg: got %b want 0", DBGRESETn); end
        checks++; if (SYSRESETn !== 1'b0) begin errors++; $display("FAIL rst_sys: got %b want 0", SYSRESETn); end
        checks++; if (RESET_CAUSE !== 4'b0001) begin errors++; $display("FAIL rst_cause: got %b want 0001", RESET_CAUSE); end
        repeat (3) tick();
        checks++; if (DBGRESETn !== 1'b0 || SYSRESETn !== 1'b0) begin
            errors++; $display("FAIL rst_hold: got dbg=%b sys=%b want 0 0", DBGRESETn, SYSRESETn);
        end
    endtask

    task automatic test_power_up();
        logic exp_dbg, exp_sys;
        @(negedge CLK);
        PORESETn = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick();
            exp_dbg = (k >= 18);
            exp_sys = (k >= 26);
            checks++; if (DBGRESETn !== exp_dbg || SYSRESETn !== exp_sys) begin
                errors++; $display("FAIL pwr_seq edge %0d: got dbg=%b sys=%b want %b %b", k, DBGRESETn, SYSRESETn, exp_dbg, exp_sys);
            end
        end
        checks++; if (RESET_CAUSE !== 4'b0001) begin errors++; $display("FAIL pwr_cause: got %b want 0001", RESET_CAUSE); end
    endtask

    task automatic test_lock_loss();
        logic exp_dbg, exp_sys;
        @(negedge CLK);
        PLL_LOCKED = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp_dbg = (k < 3);
            checks++; if (DBGRESETn !== exp_dbg || SYSRESETn !== exp_dbg) begin
                errors++; $display("FAIL lock_drop edge %0d: got dbg=%b sys=%b want %b %b", k, DBGRESETn, SYSRESETn, exp_dbg, exp_dbg);
            end
        end
        checks++; if (RESET_CAUSE !== 4'b0100) begin errors++; $display("FAIL lock_cause: got %b want 0100", RESET_CAUSE); end
        repeat (2) tick();
        @(negedge CLK);
        PLL_LOCKED = 2'b11;
        for (int k = 1; k <= 26; k++) begin
            tick();
            exp_dbg = (k >= 18);
            exp_sys = (k >= 26);
            checks++; if (DBGRESETn !== exp_dbg || SYSRESETn !== exp_sys) begin
                errors++; $display("FAIL lock_recover edge %0d: got dbg=%b sys=%b want %b %b", k, DBGRESETn, SYSRESETn, exp_dbg, exp_sys);
            end
        end
        checks++; if (RESET_CAUSE !== 4'b0100) begin errors++; $display("FAIL lock_cause_hold: got %b want 0100", RESET_CAUSE); end
    endtask

    task automatic test_bounce_press();
        logic exp_dbg, exp_sys;
        @(negedge CLK);
        BTN_RESET = 1'b1;
        repeat (3) tick();
        BTN_RESET = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++; if (DBGRESETn !== 1'b1 || SYSRESETn !== 1'b1) begin
                errors++; $display("FAIL bounce edge %0d: got dbg=%b sys=%b want 1 1", k, DBGRESETn, SYSRESETn);
            end
        end
        @(negedge CLK);
        BTN_RESET = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 10) BTN_RESET = 1'b0;
            exp_dbg = (k < 7) || (k >= 32);
            exp_sys = (k < 7) || (k >= 40);
            checks++; if (DBGRESETn !== exp_dbg || SYSRESETn !== exp_sys) begin
                errors++; $display("FAIL press edge %0d: got dbg=%b sys=%b want %b %b", k, DBGRESETn, SYSRESETn, exp_dbg, exp_sys);
            end
            if (k == 7) begin
                checks++; if (RESET_CAUSE !== 4'b0010) begin errors++; $display("FAIL press_cause: got %b want 0010", RESET_CAUSE); end
            end
        end
    endtask

    task automatic test_sysreq();
        logic exp_sys;
        @(negedge CLK);
        SYSRESETREQ = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) SYSRESETREQ = 1'b0;
            exp_sys = (k >= 5);
            checks++; if (DBGRESETn !== 1'b1 || SYSRESETn !== exp_sys) begin
                errors++; $display("FAIL sysreq_pulse edge %0d: got dbg=%b sys=%b want 1 %b", k, DBGRESETn, SYSRESETn, exp_sys);
            end
            if (k == 1) begin
                checks++; if (RESET_CAUSE !== 4'b1000) begin errors++; $display("FAIL sysreq_cause: got %b want 1000", RESET_CAUSE); end
            end
        end
        @(negedge CLK);
        SYSRESETREQ = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 12) SYSRESETREQ = 1'b0;
            exp_sys = (k == 5) || (k == 10) || (k >= 15);
            checks++; if (DBGRESETn !== 1'b1 || SYSRESETn !== exp_sys) begin
                errors++; $display("FAIL sysreq_hold edge %0d: got dbg=%b sys=%b want 1 %b", k, DBGRESETn, SYSRESETn, exp_sys);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic exp_dbg, exp_sys;
        @(negedge CLK);
        BTN_RESET = 1'b1;
        for (int k = 1; k <= 37; k++) begin
            tick();
            if (k == 4) PLL_LOCKED = 2'b10;
            if (k == 6) SYSRESETREQ = 1'b1;
            if (k == 7) begin
                SYSRESETREQ = 1'b0;
                BTN_RESET   = 1'b0;
                PLL_LOCKED  = 2'b11;
            end
            exp_dbg = (k < 7) || (k >= 29);
            exp_sys = (k < 7) || (k >= 37);
            checks++; if (DBGRESETn !== exp_dbg || SYSRESETn !== exp_sys) begin
                errors++; $display("FAIL simul edge %0d: got dbg=%b sys=%b want %b %b", k, DBGRESETn, SYSRESETn, exp_dbg, exp_sys);
            end
            if (k == 7) begin
                checks++; if (RESET_CAUSE !== 4'b0110) begin errors++; $display("FAIL simul_cause: got %b want 0110", RESET_CAUSE); end
            end
        end
    endtask

    task automatic test_async_mid();
        logic exp_dbg, exp_sys;
        @(negedge CLK);
        SYSRESETREQ = 1'b1;
        tick();
        SYSRESETREQ = 1'b0;
        tick();
        #2 PORESETn = 1'b0;
        #1;
        checks++; if (DBGRESETn !== 1'b0 || SYSRESETn !== 1'b0 || RESET_CAUSE !== 4'b0001) begin
            errors++; $display("FAIL async_sysreq: got dbg=%b sys=%b cause=%b want 0 0 0001", DBGRESETn, SYSRESETn, RESET_CAUSE);
        end
        @(negedge CLK);
        PORESETn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++; if (DBGRESETn !== 1'b0 || SYSRESETn !== 1'b0) begin
                errors++; $display("FAIL async_restart1 edge %0d: got dbg=%b sys=%b want 0 0", k, DBGRESETn, SYSRESETn);
            end
        end
        #2 PORESETn = 1'b0;
        #1;
        checks++; if (DBGRESETn !== 1'b0 || SYSRESETn !== 1'b0 || RESET_CAUSE !== 4'b0001) begin
            errors++; $display("FAIL async_count: got dbg=%b sys=%b cause=%b want 0 0 0001", DBGRESETn, SYSRESETn, RESET_CAUSE);
        end
        @(negedge CLK);
        PORESETn = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick();
            exp_dbg = (k >= 18);
            exp_sys = (k >= 26);
            checks++; if (DBGRESETn !== exp_dbg || SYSRESETn !== exp_sys) begin
                errors++; $display("FAIL async_restart2 edge %0d: got dbg=%b sys=%b want %b %b", k, DBGRESETn, SYSRESETn, exp_dbg, exp_sys);
            end
        end
        checks++; if (RESET_CAUSE !== 4'b0001) begin errors++; $display("FAIL async_cause_final: got %b want 0001", RESET_CAUSE); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_loss();
        test_bounce_press();
        test_sysreq();
        test_simultaneous();
        test_async_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
